uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered 8N1 UART transmitter that consumes the byte/strobe pair the memory controller emits on stores to the UART address. Each strobed byte is pushed into a small FIFO, so back-to-back stores from the core are never lost while a frame is in flight. The FIFO drains through a bit-timing state machine onto the serial line. The block sits between the memory controller's `uart`/`uart_we` outputs and the board TX pin.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.
- `clk` in 1: single system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart` in 8: byte to transmit, sampled when `uart_we`=1.
- `uart_we` in 1: push strobe, one byte per cycle high.
- `overflow_clr` in 1: synchronous clear of `overflow`.
- `txd` out 1: serial output, idle high.
- `tx_busy` out 1: high while a frame is on the line or FIFO is non-empty.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current entry count.
- `overflow` out 1: sticky flag, set when a push was dropped.

## Operation
- FIFO: circular buffer, read/write pointers of $clog2(FIFO_DEPTH) bits, wrap modulo depth; separate count register 0..FIFO_DEPTH.
- Push: `uart_we`=1 and not full → store `uart` at write pointer, pointer+1.
- Push while full → byte dropped, `overflow` set next edge; a pop on the same cycle does NOT rescue it. Full-ness is evaluated before the edge.
- Simultaneous push and pop (non-full) → count unchanged, both pointers advance.
- `overflow_clr`=1 clears `overflow`; a drop in the same cycle wins (flag stays set).
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO non-empty → pop head into shift register, bit counter=0, baud counter=0, go START.
  - START: `txd`=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: `txd`=shift[0], LSB first. After CLKS_PER_BIT cycles shift right, bit index+1; after bit 7 → STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty → pop and go START directly (no idle gap); else → IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at the state/bit boundary.
- `txd` is registered; it is driven from FSM state and shift register only.
- `tx_busy` = (state≠IDLE) | (count≠0).

## Timing
- Reset values: `txd`=1, `tx_busy`=0, `fifo_full`=0, `fifo_level`=0, `overflow`=0; FSM=IDLE, pointers/counters=0. Reset mid-frame aborts immediately and `txd` returns high asynchronously; FIFO contents are discarded.
- Push visible in `fifo_level` one edge after the sampling edge.
- Latency: write sampled at edge N, FIFO empty and IDLE → pop at edge N+1 → `txd` low from edge N+2.
- Frame length: exactly 10×CLKS_PER_BIT cycles from `txd` fall to the end of the stop bit.
- Back-to-back bytes: the next start bit begins on the cycle after the last stop-bit cycle; no extra idle.
- `fifo_level` decrements on the pop edge (frame start), not at frame end.
- No backpressure to the core: a full FIFO means a drop plus `overflow`.

## Test plan
- Single byte, CLKS_PER_BIT=4: push 0xA5 → `txd` low 2 edges later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high; total 40 cycles; `tx_busy` falls after the stop bit.
- Burst: push 0x01,0x02,0x03 on consecutive cycles → `fifo_level` peaks at 2 after the first pop; three contiguous 40-cycle frames with no idle gap; decoded bytes in order.
- Overflow, FIFO_DEPTH=4: push 6 bytes in 6 consecutive cycles starting from idle → first byte popped, next 4 fill FIFO, 6th dropped; `overflow`=1, `fifo_full`=1; transmitted bytes 1-5 only.
- Full plus simultaneous pop: FIFO full, push coincides with the STOP→START pop → byte dropped, `overflow`=1, level = DEPTH-1.
- Overflow clear: assert `overflow_clr` alone → `overflow`=0 next edge; assert it with a dropped push → stays 1.
- Async reset mid-DATA: drop `rst_n` during bit 3 → `txd`=1 immediately, level=0, `overflow`=0; after release, a fresh push transmits a correct frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte/strobe push port from the memory controller plus the serial line and FIFO status.
// The master side is the store-issuing core; the slave side is the transmitter.
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    uart;
    logic          uart_we;
    logic          overflow_clr;
    logic          txd;
    logic          tx_busy;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    modport master (
        output uart, uart_we, overflow_clr,
        input  txd, tx_busy, fifo_full, fifo_level, overflow
    );

    modport slave (
        input  uart, uart_we, overflow_clr,
        output txd, tx_busy, fifo_full, fifo_level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: strobed bytes enter a circular FIFO and drain through
// a bit-timing FSM onto txd.
//   state   | meaning
//   IDLE    | line high, waiting for a FIFO entry
//   START   | start bit (low) for CLKS_PER_BIT cycles
//   DATA    | eight data bits, LSB first
//   STOP    | stop bit (high); pops straight into START when more data is queued
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          txd_q, txd_nxt;
    logic          overflow_q;
    logic          full, empty, push, drop, pop, shift_en, baud_done;

    // Full-ness is judged before the edge, so a same-cycle pop never rescues a push.
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign push      = bus.uart_we & ~full;
    assign drop      = bus.uart_we & full;
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty)                      state_nxt = S_START;
            S_START: if (baud_done)                   state_nxt = S_DATA;
            S_DATA:  if (baud_done && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (baud_done)                   state_nxt = empty ? S_IDLE : S_START;
            default:                                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        shift_en = 1'b0;
        txd_nxt  = 1'b1;
        case (state)
            S_IDLE:  pop = ~empty;
            S_START: txd_nxt = 1'b0;
            S_DATA: begin
                txd_nxt  = shift[0];
                shift_en = baud_done;
            end
            S_STOP:  pop = baud_done & ~empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.uart;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)                  overflow_q <= 1'b1;
            else if (bus.overflow_clr) overflow_q <= 1'b0;
        end
    end

    // txd is a registered copy of the current state's line level, one cycle behind the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            txd_q    <= 1'b1;
        end else begin
            txd_q <= txd_nxt;
            if (pop || state == S_IDLE || baud_done) baud_cnt <= '0;
            else                                     baud_cnt <= baud_cnt + 1'b1;
            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    assign bus.txd        = txd_q;
    assign bus.tx_busy    = (state != S_IDLE) | ~empty;
    assign bus.fifo_full  = full;
    assign bus.fifo_level = count;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4; a line monitor
// decodes txd frames into a queue that the scenario tasks compare against.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [8:0] rx_q [$];
    int         rx_t [$];

    uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples mid-bit; bit 8 of a queued entry flags a framing error.
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && bus_if.txd === 1'b0) begin : frame
            logic [7:0] d;
            bit ok;
            bit ab;
            int st;
            ok = 1'b1; ab = 1'b0; st = cyc; d = 8'h00;
            repeat (CPB / 2) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
            if (bus_if.txd !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
                d[i] = bus_if.txd;
            end
            repeat (CPB) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
            if (bus_if.txd !== 1'b1) ok = 1'b0;
            repeat (CPB - CPB / 2 - 1) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
            if (bus_if.txd !== 1'b1) ok = 1'b0;
            if (!ab) begin
                rx_q.push_back({~ok, d});
                rx_t.push_back(st);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((bus_if.tx_busy !== 1'b0 || bus_if.txd !== 1'b1) && n < max) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= max) begin n_err++; $display("FAIL wait_idle: tx_busy=%b after %0d cycles, required 0", bus_if.tx_busy, n); end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        bus_if.uart = 8'h00; bus_if.uart_we = 1'b0; bus_if.overflow_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus_if.txd !== 1'b1)        begin n_err++; $display("FAIL rst_txd: got %b expected 1", bus_if.txd); end
        n_cmp++; if (bus_if.tx_busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy: got %b expected 0", bus_if.tx_busy); end
        n_cmp++; if (bus_if.fifo_full !== 1'b0)  begin n_err++; $display("FAIL rst_full: got %b expected 0", bus_if.fifo_full); end
        n_cmp++; if (bus_if.fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", bus_if.fifo_level); end
        n_cmp++; if (bus_if.overflow !== 1'b0)   begin n_err++; $display("FAIL rst_ovf: got %b expected 0", bus_if.overflow); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus_if.txd !== 1'b1 || bus_if.tx_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got txd=%b busy=%b expected 1/0", bus_if.txd, bus_if.tx_busy); end
    endtask

    task automatic test_single();
        rx_q.delete(); rx_t.delete();
        bus_if.uart = 8'hA5; bus_if.uart_we = 1'b1;
        tick();
        bus_if.uart_we = 1'b0;
        n_cmp++; if (bus_if.fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level_push: got %0d expected 1", bus_if.fifo_level); end
        n_cmp++; if (bus_if.txd !== 1'b1)        begin n_err++; $display("FAIL single_txd_n: got %b expected 1", bus_if.txd); end
        n_cmp++; if (bus_if.tx_busy !== 1'b1)    begin n_err++; $display("FAIL single_busy_n: got %b expected 1", bus_if.tx_busy); end
        tick();
        n_cmp++; if (bus_if.fifo_level !== 3'd0) begin n_err++; $display("FAIL single_level_pop: got %0d expected 0", bus_if.fifo_level); end
        n_cmp++; if (bus_if.txd !== 1'b1)        begin n_err++; $display("FAIL single_txd_n1: got %b expected 1", bus_if.txd); end
        tick();
        n_cmp++; if (bus_if.txd !== 1'b0)        begin n_err++; $display("FAIL single_start: got %b expected 0", bus_if.txd); end
        repeat (38) tick();
        n_cmp++; if (bus_if.tx_busy !== 1'b1 || bus_if.txd !== 1'b1) begin n_err++; $display("FAIL single_stop: got busy=%b txd=%b expected 1/1", bus_if.tx_busy, bus_if.txd); end
        tick();
        n_cmp++; if (bus_if.tx_busy !== 1'b0)    begin n_err++; $display("FAIL single_busy_end: got %b expected 0", bus_if.tx_busy); end
        repeat (2) tick();
        n_cmp++; if (rx_q.size() !== 1)          begin n_err++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
        n_cmp++; if (rx_q.size() < 1 || rx_q[0] !== 9'h0A5) begin n_err++; $display("FAIL single_byte: got %h expected 0a5", (rx_q.size() > 0) ? rx_q[0] : 9'h1FF); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [3];
        e = '{8'h01, 8'h02, 8'h03};
        rx_q.delete(); rx_t.delete();
        bus_if.uart_we = 1'b1;
        bus_if.uart = 8'h01; tick();
        n_cmp++; if (bus_if.fifo_level !== 3'd1) begin n_err++; $display("FAIL burst_level0: got %0d expected 1", bus_if.fifo_level); end
        bus_if.uart = 8'h02; tick();
        n_cmp++; if (bus_if.fifo_level !== 3'd1) begin n_err++; $display("FAIL burst_level1: got %0d expected 1", bus_if.fifo_level); end
        bus_if.uart = 8'h03; tick();
        bus_if.uart_we = 1'b0;
        n_cmp++; if (bus_if.fifo_level !== 3'd2) begin n_err++; $display("FAIL burst_peak: got %0d expected 2", bus_if.fifo_level); end
        repeat (38) tick();
        n_cmp++; if (bus_if.fifo_level !== 3'd2) begin n_err++; $display("FAIL burst_level_pre_pop: got %0d expected 2", bus_if.fifo_level); end
        tick();
        n_cmp++; if (bus_if.fifo_level !== 3'd1) begin n_err++; $display("FAIL burst_level_pop: got %0d expected 1", bus_if.fifo_level); end
        wait_idle(200);
        n_cmp++; if (rx_q.size() !== 3) begin n_err++; $display("FAIL burst_count: got %0d expected 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= rx_q.size() || rx_q[i] !== {1'b0, e[i]}) begin
                n_err++; $display("FAIL burst_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 9'h1FF, {1'b0, e[i]});
            end
        end
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (i >= rx_t.size() || rx_t[i] - rx_t[i-1] !== 10 * CPB) begin
                n_err++; $display("FAIL burst_gap%0d: got %0d expected %0d", i, (i < rx_t.size()) ? rx_t[i] - rx_t[i-1] : -1, 10 * CPB);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [6];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rx_q.delete(); rx_t.delete();
        bus_if.uart_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.uart = b[i];
            tick();
        end
        n_cmp++; if (bus_if.fifo_full !== 1'b1 || bus_if.fifo_level !== 3'd4 || bus_if.overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_fill: got full=%b level=%0d ovf=%b expected 1/4/0", bus_if.fifo_full, bus_if.fifo_level, bus_if.overflow); end
        bus_if.uart = b[5];
        tick();
        bus_if.uart_we = 1'b0;
        n_cmp++; if (bus_if.overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_set: got %b expected 1", bus_if.overflow); end
        n_cmp++; if (bus_if.fifo_full !== 1'b1 || bus_if.fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got full=%b level=%0d expected 1/4", bus_if.fifo_full, bus_if.fifo_level); end
    endtask

    task automatic test_overflow_clr();
        bus_if.overflow_clr = 1'b1;
        tick();
        bus_if.overflow_clr = 1'b0;
        n_cmp++; if (bus_if.overflow !== 1'b0)   begin n_err++; $display("FAIL clr_alone: got %b expected 0", bus_if.overflow); end
        n_cmp++; if (bus_if.fifo_level !== 3'd4) begin n_err++; $display("FAIL clr_level: got %0d expected 4", bus_if.fifo_level); end
    endtask

    task automatic test_full_pop();
        repeat (34) tick();
        n_cmp++; if (bus_if.fifo_full !== 1'b1 || bus_if.overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_pre: got full=%b ovf=%b expected 1/0", bus_if.fifo_full, bus_if.overflow); end
        bus_if.uart = 8'h77; bus_if.uart_we = 1'b1;
        tick();
        bus_if.uart_we = 1'b0;
        n_cmp++; if (bus_if.overflow !== 1'b1)   begin n_err++; $display("FAIL fullpop_ovf: got %b expected 1", bus_if.overflow); end
        n_cmp++; if (bus_if.fifo_level !== 3'd3 || bus_if.fifo_full !== 1'b0) begin n_err++; $display("FAIL fullpop_level: got level=%0d full=%b expected 3/0", bus_if.fifo_level, bus_if.fifo_full); end
    endtask

    task automatic test_clr_with_drop();
        logic [7:0] e [6];
        e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h88};
        bus_if.overflow_clr = 1'b1;
        tick();
        bus_if.overflow_clr = 1'b0;
        n_cmp++; if (bus_if.overflow !== 1'b0)   begin n_err++; $display("FAIL clr2: got %b expected 0", bus_if.overflow); end
        bus_if.uart = 8'h88; bus_if.uart_we = 1'b1;
        tick();
        n_cmp++; if (bus_if.fifo_full !== 1'b1)  begin n_err++; $display("FAIL refill: got %b expected 1", bus_if.fifo_full); end
        bus_if.uart = 8'h99; bus_if.overflow_clr = 1'b1;
        tick();
        bus_if.uart_we = 1'b0; bus_if.overflow_clr = 1'b0;
        n_cmp++; if (bus_if.overflow !== 1'b1)   begin n_err++; $display("FAIL clr_vs_drop: got %b expected 1", bus_if.overflow); end
        n_cmp++; if (bus_if.fifo_level !== 3'd4) begin n_err++; $display("FAIL clr_vs_drop_level: got %0d expected 4", bus_if.fifo_level); end
        wait_idle(400);
        n_cmp++; if (rx_q.size() !== 6) begin n_err++; $display("FAIL ovf_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= rx_q.size() || rx_q[i] !== {1'b0, e[i]}) begin
                n_err++; $display("FAIL ovf_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 9'h1FF, {1'b0, e[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        n_cmp++; if (bus_if.overflow !== 1'b1) begin n_err++; $display("FAIL mid_pre_ovf: got %b expected 1", bus_if.overflow); end
        rx_q.delete(); rx_t.delete();
        bus_if.uart_we = 1'b1;
        bus_if.uart = 8'hF0; tick();
        bus_if.uart = 8'h12; tick();
        bus_if.uart = 8'h34; tick();
        bus_if.uart_we = 1'b0;
        repeat (17) tick();
        n_cmp++; if (bus_if.txd !== 1'b0 || bus_if.fifo_level !== 3'd2) begin n_err++; $display("FAIL mid_bit3: got txd=%b level=%0d expected 0/2", bus_if.txd, bus_if.fifo_level); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.txd !== 1'b1)        begin n_err++; $display("FAIL mid_rst_txd: got %b expected 1", bus_if.txd); end
        n_cmp++; if (bus_if.fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_rst_level: got %0d expected 0", bus_if.fifo_level); end
        n_cmp++; if (bus_if.overflow !== 1'b0)   begin n_err++; $display("FAIL mid_rst_ovf: got %b expected 0", bus_if.overflow); end
        n_cmp++; if (bus_if.tx_busy !== 1'b0)    begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", bus_if.tx_busy); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (50) tick();
        n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL mid_no_frames: got %0d expected 0", rx_q.size()); end
        rx_q.delete(); rx_t.delete();
        bus_if.uart = 8'h3C; bus_if.uart_we = 1'b1;
        tick();
        bus_if.uart_we = 1'b0;
        wait_idle(100);
        n_cmp++; if (rx_q.size() !== 1 || rx_q[0] !== 9'h03C) begin n_err++; $display("FAIL mid_fresh: got n=%0d byte=%h expected 1/03c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1FF); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_overflow_clr();
        test_full_pop();
        test_clr_with_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
